// File: rtl/btn_press_conditioner_pkg.sv
// btn_cond_pkg: shared types and constants for btn_press_conditioner.
//   state_t        debounce FSM state encoding
//   PRESS_COUNT_W  width of the accepted-press counter output
package btn_cond_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM    = 2'd1,
      HELD   = 2'd2,
      DISARM = 2'd3
   } state_t;

   localparam int PRESS_COUNT_W = 8;

endpackage

// File: rtl/btn_press_conditioner_sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs, cleared by reset.
// Ports:
//   i_clk  in   1      clock
//   i_rst  in   1      asynchronous active-high reset
//   i_d    in   WIDTH  asynchronous input
//   o_q    out  WIDTH  synchronised output (2-cycle latency)
// Multi-bit use is only for quasi-static buses where per-bit skew is harmless.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/btn_press_conditioner.sv
// btn_press_conditioner: turns a raw bouncing push-button into clean press
// events (strobe, debounced level, captured switch digit, press counter).
// Optional build macro: REPEAT_EN enables auto-repeat while the button is held.
// Ports:
//   i_clk          in   1         system clock
//   i_rst          in   1         asynchronous active-high reset
//   i_btn_raw      in   1         raw button, asynchronous, bouncing
//   i_sw_digit     in   DIGIT_W   raw slide switches, quasi-static
//   o_press_pulse  out  1         one-cycle strobe per accepted press / repeat
//   o_press_level  out  1         debounced button level
//   o_digit_out    out  DIGIT_W   switch digit captured with each strobe
//   o_press_count  out  8         accepted presses since reset, wrapping
//
// state  | meaning
// IDLE   | released and stable, waiting for btn_s to rise
// ARM    | btn_s high, counting towards an accepted press
// HELD   | press accepted, press_level high
// DISARM | btn_s low while held, counting towards an accepted release
module btn_press_conditioner
   import btn_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DIGIT_W         = 4
`ifdef REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 12500000
`endif
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_btn_raw,
   input  logic [DIGIT_W-1:0]       i_sw_digit,
   output logic                     o_press_pulse,
   output logic                     o_press_level,
   output logic [DIGIT_W-1:0]       o_digit_out,
   output logic [PRESS_COUNT_W-1:0] o_press_count
);

   localparam int              CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                     w_btn_s;
   logic [DIGIT_W-1:0]       w_sw_s;
   logic [CNT_W-1:0]         w_cnt_inc;
   logic                     w_cnt_done;

   state_t                   r_state;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_pulse;
   logic                     r_level;
   logic [DIGIT_W-1:0]       r_digit;
   logic [PRESS_COUNT_W-1:0] r_count;

   sync_2ff #(.WIDTH(1)) u_sync_btn (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_btn_raw),
      .o_q   (w_btn_s)
   );

   sync_2ff #(.WIDTH(DIGIT_W)) u_sync_sw (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_sw_digit),
      .o_q   (w_sw_s)
   );

   // Saturating increment; "done" looks at the value the counter is about to
   // take so the accepting edge is the one on which it reaches DEBOUNCE_CYCLES-1.
   // The >= also covers DEBOUNCE_CYCLES=1, where the first ARM cycle accepts.
   assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_cnt_done = (w_cnt_inc >= CNT_TC);

`ifdef REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   logic [RPT_W-1:0] r_rpt_cnt;
   logic             r_rpt_first;
   logic [RPT_W-1:0] w_rpt_inc;
   logic [RPT_W-1:0] w_rpt_tc;
   logic             w_rpt_fire;

   // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
   assign w_rpt_inc  = r_rpt_cnt + RPT_W'(1);
   assign w_rpt_tc   = r_rpt_first ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD);
   assign w_rpt_fire = (w_rpt_inc == w_rpt_tc);
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
         r_level <= 1'b0;
         r_digit <= '0;
         r_count <= '0;
`ifdef REPEAT_EN
         r_rpt_cnt   <= '0;
         r_rpt_first <= 1'b1;
`endif
      end else begin
         r_pulse <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_btn_s) begin
                  r_state <= ARM;
                  r_cnt   <= '0;
               end
            end
            ARM: begin
               if (!w_btn_s) begin
                  r_state <= IDLE;
               end else if (w_cnt_done) begin
                  r_state <= HELD;
                  r_cnt   <= '0;
                  r_pulse <= 1'b1;
                  r_level <= 1'b1;
                  r_digit <= w_sw_s;
                  r_count <= r_count + PRESS_COUNT_W'(1);
`ifdef REPEAT_EN
                  r_rpt_cnt   <= '0;
                  r_rpt_first <= 1'b1;
`endif
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            HELD: begin
               if (!w_btn_s) begin
                  r_state <= DISARM;
                  r_cnt   <= '0;
`ifdef REPEAT_EN
                  r_rpt_cnt   <= '0;
                  r_rpt_first <= 1'b1;
               end else if (w_rpt_fire) begin
                  r_pulse     <= 1'b1;
                  r_digit     <= w_sw_s;
                  r_count     <= r_count + PRESS_COUNT_W'(1);
                  r_rpt_cnt   <= '0;
                  r_rpt_first <= 1'b0;
               end else begin
                  r_rpt_cnt <= w_rpt_inc;
`endif
               end
            end
            DISARM: begin
               // A bounce back to high returns to HELD without a new strobe.
               if (w_btn_s) begin
                  r_state <= HELD;
`ifdef REPEAT_EN
                  r_rpt_cnt   <= '0;
                  r_rpt_first <= 1'b1;
`endif
               end else if (w_cnt_done) begin
                  r_state <= IDLE;
                  r_level <= 1'b0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_press_pulse = r_pulse;
   assign o_press_level = r_level;
   assign o_digit_out   = r_digit;
   assign o_press_count = r_count;

endmodule

// File: tb/tb_btn_press_conditioner.sv
// Self-checking bench for btn_press_conditioner (DEBOUNCE_CYCLES=8,
// REPEAT_DELAY=20, REPEAT_PERIOD=6). Works with or without REPEAT_EN.
module tb_btn_press_conditioner;

   localparam int DEB = 8;
   localparam int RD  = 20;
   localparam int RP  = 6;
`ifdef REPEAT_EN
   localparam int T1_NP = 2;
`else
   localparam int T1_NP = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_raw;
   logic [3:0] sw_digit;
   logic       press_pulse;
   logic       press_level;
   logic [3:0] digit_out;
   logic [7:0] press_count;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   btn_press_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .DIGIT_W         (4)
`ifdef REPEAT_EN
      ,
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
`endif
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_btn_raw     (btn_raw),
      .i_sw_digit    (sw_digit),
      .o_press_pulse (press_pulse),
      .o_press_level (press_level),
      .o_digit_out   (digit_out),
      .o_press_count (press_count)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the button is seen two clocks late; a level change is
   // accepted once DEB consecutive samples disagree with the accepted level.
   bit         m_h1, m_h2, m_s, m_level, m_was, m_pulse, m_first;
   logic [3:0] m_sw1, m_sw2, m_sw, m_digit;
   logic [7:0] m_count;
   int         m_run, m_run_before, m_rep;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_h1 = 0; m_h2 = 0; m_sw1 = 0; m_sw2 = 0;
            m_level = 0; m_run = 0; m_pulse = 0; m_digit = 0;
            m_count = 0; m_rep = 0; m_first = 1;
         end else begin
            m_s = m_h2; m_sw = m_sw2;
            m_h2 = m_h1; m_h1 = btn_raw;
            m_sw2 = m_sw1; m_sw1 = sw_digit;
            m_pulse = 0;
            m_was = m_level;
            m_run_before = m_run;
            if (m_s != m_level) begin
               m_run++;
               if (m_run == DEB) begin
                  m_level = m_s;
                  m_run = 0;
                  if (m_s) begin
                     m_pulse = 1; m_digit = m_sw; m_count = m_count + 8'd1;
                  end
               end
            end else begin
               m_run = 0;
            end
`ifdef REPEAT_EN
            if (m_was && m_level) begin
               if (m_s && m_run_before == 0) begin
                  m_rep++;
                  if (m_rep == (m_first ? RD : RP)) begin
                     m_pulse = 1; m_digit = m_sw; m_count = m_count + 8'd1;
                     m_rep = 0; m_first = 0;
                  end
               end else begin
                  m_rep = 0; m_first = 1;
               end
            end else begin
               m_rep = 0; m_first = 1;
            end
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("mdl_pulse", int'(press_pulse), int'(m_pulse));
         check("mdl_level", int'(press_level), int'(m_level));
         check("mdl_digit", int'(digit_out), int'(m_digit));
         check("mdl_count", int'(press_count), int'(m_count));
      end
   end

   typedef struct {
      int         hi;
      logic [3:0] dig;
      int         exp_np;
      logic [3:0] exp_digit;
   } vec_t;

   vec_t vecs[6];
   int   exp_t[5];

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int np, first, falls, exp_cnt, len;
      bit prev_lvl, lvl_seen, val;
      int times[$];

      vecs[0] = '{hi: 5,  dig: 4'h3, exp_np: 0, exp_digit: 4'h5};
      vecs[1] = '{hi: 7,  dig: 4'h9, exp_np: 0, exp_digit: 4'h5};
      vecs[2] = '{hi: 8,  dig: 4'h6, exp_np: 1, exp_digit: 4'h6};
      vecs[3] = '{hi: 12, dig: 4'hA, exp_np: 1, exp_digit: 4'hA};
      vecs[4] = '{hi: 3,  dig: 4'hC, exp_np: 0, exp_digit: 4'hA};
      vecs[5] = '{hi: 20, dig: 4'hF, exp_np: 1, exp_digit: 4'hF};
      exp_t = '{10, 30, 36, 42, 48};

      rst = 1'b1; btn_raw = 1'b0; sw_digit = 4'h0;
      repeat (3) @(negedge clk);
      check("rst_pulse", int'(press_pulse), 0);
      check("rst_level", int'(press_level), 0);
      check("rst_digit", int'(digit_out), 0);
      check("rst_count", int'(press_count), 0);
      #2 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      // 1: clean press
      sw_digit = 4'h5; btn_raw = 1'b1; np = 0; first = -1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (press_pulse) begin np++; if (first < 0) first = i; end
      end
      check("t1_first_pulse", first, 10);
      check("t1_npulse", np, T1_NP);
      check("t1_digit", int'(digit_out), 5);
      check("t1_level_held", int'(press_level), 1);
      btn_raw = 1'b0; first = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (!press_level && first < 0) first = i;
      end
      check("t1_release_lat", first, 10);
      exp_cnt = T1_NP;
      check("t1_count", int'(press_count), exp_cnt);

      // table: pulse width around the debounce boundary
      for (int v = 0; v < 6; v++) begin
         sw_digit = vecs[v].dig; btn_raw = 1'b1; np = 0;
         repeat (vecs[v].hi) begin
            @(negedge clk); if (press_pulse) np++;
         end
         btn_raw = 1'b0;
         repeat (14) begin
            @(negedge clk); if (press_pulse) np++;
         end
         exp_cnt += vecs[v].exp_np;
         check($sformatf("vec%0d_np", v), np, vecs[v].exp_np);
         check($sformatf("vec%0d_digit", v), int'(digit_out), int'(vecs[v].exp_digit));
         check($sformatf("vec%0d_level", v), int'(press_level), 0);
         check($sformatf("vec%0d_count", v), int'(press_count), exp_cnt);
      end

      // 2: bouncing press
      sw_digit = 4'h2; np = 0; first = -1;
      for (int k = 0; k < 8; k++) begin
         btn_raw = (k % 2 == 0);
         repeat (3) begin @(negedge clk); if (press_pulse) np++; end
      end
      btn_raw = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (press_pulse) begin np++; if (first < 0) first = i; end
      end
      check("t2_npulse", np, 1);
      check("t2_first_pulse", first, 10);
      btn_raw = 1'b0;
      repeat (14) @(negedge clk);

      // 3: short glitch
      np = 0; lvl_seen = 0; btn_raw = 1'b1;
      repeat (5) begin @(negedge clk); if (press_pulse) np++; if (press_level) lvl_seen = 1; end
      btn_raw = 1'b0;
      repeat (15) begin @(negedge clk); if (press_pulse) np++; if (press_level) lvl_seen = 1; end
      check("t3_npulse", np, 0);
      check("t3_level", int'(lvl_seen), 0);

      // 4: release bounce
      np = 0; falls = 0; prev_lvl = press_level; btn_raw = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) btn_raw = (k % 2 == 0);
         repeat (k == 0 ? 15 : 2) begin
            @(negedge clk);
            if (press_pulse) np++;
            if (prev_lvl && !press_level) falls++;
            prev_lvl = press_level;
         end
      end
      btn_raw = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (press_pulse) np++;
         if (prev_lvl && !press_level) falls++;
         prev_lvl = press_level;
      end
      check("t4_npulse", np, 1);
      check("t4_falls", falls, 1);

      // 5: reset while held
      sw_digit = 4'h7; btn_raw = 1'b1;
      repeat (15) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_level", int'(press_level), 0);
      check("t5_rst_count", int'(press_count), 0);
      check("t5_rst_digit", int'(digit_out), 0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      first = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (press_pulse && first < 0) first = i;
      end
      check("t5_first_pulse", first, 10);
      check("t5_count", int'(press_count), 1);
      btn_raw = 1'b0;
      repeat (15) @(negedge clk);

`ifdef REPEAT_EN
      // 6: auto-repeat timing
      do_reset();
      btn_raw = 1'b1; sw_digit = 4'h3;
      times.delete();
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (press_pulse) times.push_back(i);
      end
      check("t6_nrepeat", times.size(), 5);
      for (int j = 0; j < 5; j++)
         check($sformatf("t6_time%0d", j), (j < times.size()) ? times[j] : -1, exp_t[j]);
      check("t6_count", int'(press_count), 5);
      btn_raw = 1'b0;
      repeat (15) @(negedge clk);
`endif

      // press_count wrap
      do_reset();
      np = 0;
      for (int p = 0; p < 256; p++) begin
         sw_digit = 4'(p);
         btn_raw = 1'b1;
         repeat (10) begin @(negedge clk); if (press_pulse) np++; end
         btn_raw = 1'b0;
         repeat (12) begin @(negedge clk); if (press_pulse) np++; end
         if (p == 254) check("wrap_count_255", int'(press_count), 255);
      end
      check("wrap_npulse", np, 256);
      check("wrap_count_0", int'(press_count), 0);

      // random stimulus against the model
      val = 1'b0;
      for (int r = 0; r < 250; r++) begin
         len = $urandom_range(1, 14);
         val = ~val;
         btn_raw = val;
         sw_digit = 4'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk);
            #2 rst = 1'b0;
         end
         repeat (len) @(negedge clk);
      end
      btn_raw = 1'b0;
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL timeout: simulation did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
